arith_unit_seq: RTL

//  Registered, parametrised add/sub unit; drives the internal bus IB_Alu through a tristate.

---
 rtl/arith_unit_seq_if.sv | 31 +++
 rtl/arith_unit_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq_if.sv
// arith_unit_seq_if: request, status and bus signals between the operand side and the add/sub unit.
// Latency: none, wiring only.
// Backpressure: carried by Busy; a requester holds Start only while the unit is idle.
interface arith_unit_seq_if #(
   parameter int WIDTH = 4
);
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             EnableAlu;
   logic             Busy;
   logic             Done;
   logic             Err;
   wire  [WIDTH-1:0] IB_Alu;
   logic [WIDTH-1:0] ResHi;
   logic             Carry;
   logic             Zero;
   logic             Neg;
   logic             Ovf;

   modport master (
      output Start, Op, A, B, EnableAlu,
      input  Busy, Done, Err, IB_Alu, ResHi, Carry, Zero, Neg, Ovf
   );

   modport slave (
      input  Start, Op, A, B, EnableAlu,
      output Busy, Done, Err, IB_Alu, ResHi, Carry, Zero, Neg, Ovf
   );
endinterface

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: registered add/sub/carry/compare unit with flags, result driven onto IB_Alu via tristate; ARITH_SEQ_MUL_EN adds a shift-add MUL.
// Latency: Done rises 2 cycles after the accepting Start edge (WIDTH+2 for MUL); Done lasts one cycle.
// Backpressure: one operation in flight; Start is ignored while Busy and accepted again once back in IDLE.
module arith_unit_seq #(
   parameter int WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   arith_unit_seq_if.slave alu
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_ADC = 3'b010;
   localparam logic [2:0] OP_SBC = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;
`ifdef ARITH_SEQ_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam int         CNT_W  = $clog2(WIDTH);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
`ifdef ARITH_SEQ_MUL_EN
      S_MUL  = 2'd3,
`endif
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
`ifdef ARITH_SEQ_MUL_EN
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   logic [WIDTH-1:0] add_a;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic             sum_ovf;

   // Shared WIDTH-bit adder: subtraction forms use ~A with the carry-in selecting borrow handling.
   always_comb begin
      add_a   = a_q;
      add_cin = 1'b0;
      case (op_q)
         OP_SUB, OP_CMP: begin
            add_a   = ~a_q;
            add_cin = 1'b1;
         end
         OP_ADC: add_cin = carry_q;
         OP_SBC: begin
            add_a   = ~a_q;
            add_cin = carry_q;
         end
         default: ;
      endcase
      sum     = {1'b0, b_q} + {1'b0, add_a} + {{WIDTH{1'b0}}, add_cin};
      sum_ovf = (b_q[WIDTH-1] == add_a[WIDTH-1]) && (sum[WIDTH-1] != b_q[WIDTH-1]);
   end

   // Next-state and datapath updates; every register holds unless its state changes it.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      done_d  = 1'b0;
`ifdef ARITH_SEQ_MUL_EN
      res_hi_d = res_hi_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (alu.Start) begin
               op_d  = alu.Op;
               a_d   = alu.A;
               b_d   = alu.B;
               err_d = 1'b0;
`ifdef ARITH_SEQ_MUL_EN
               if (alu.Op == OP_MUL) begin
                  acc_d   = '0;
                  mcand_d = {{WIDTH{1'b0}}, alu.A};
                  cnt_d   = '0;
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
`else
               state_d = S_EXEC;
`endif
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                  res_d   = sum[WIDTH-1:0];
                  carry_d = sum[WIDTH];
                  zero_d  = (sum[WIDTH-1:0] == '0);
                  neg_d   = sum[WIDTH-1];
                  ovf_d   = sum_ovf;
               end
               OP_CMP: begin
                  carry_d = sum[WIDTH];
                  zero_d  = (sum[WIDTH-1:0] == '0);
                  neg_d   = sum[WIDTH-1];
                  ovf_d   = sum_ovf;
               end
`ifdef ARITH_SEQ_MUL_EN
               // Product is already complete in acc; this cycle only publishes it.
               OP_MUL: begin
                  res_d    = acc_q[WIDTH-1:0];
                  res_hi_d = acc_q[2*WIDTH-1:WIDTH];
                  carry_d  = |acc_q[2*WIDTH-1:WIDTH];
                  zero_d   = (acc_q == '0);
                  neg_d    = 1'b0;
                  ovf_d    = 1'b0;
               end
`endif
               default: err_d = 1'b1;
            endcase
            state_d = S_DONE;
         end
`ifdef ARITH_SEQ_MUL_EN
         // One multiplier bit per cycle, LSB first; B is consumed by shifting it right.
         S_MUL: begin
            if (b_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_EXEC;
            end
         end
`endif
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything, including any pending Done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef ARITH_SEQ_MUL_EN
         res_hi_q <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         done_q  <= done_d;
`ifdef ARITH_SEQ_MUL_EN
         res_hi_q <= res_hi_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign alu.Busy  = (state_q != S_IDLE);
   assign alu.Done  = done_q;
   assign alu.Err   = err_q;
   assign alu.Carry = carry_q;
   assign alu.Zero  = zero_q;
   assign alu.Neg   = neg_q;
   assign alu.Ovf   = ovf_q;
`ifdef ARITH_SEQ_MUL_EN
   assign alu.ResHi = res_hi_q;
`else
   assign alu.ResHi = '0;
`endif
   // Bus drive follows EnableAlu combinationally so the bus can be released mid-cycle.
   assign alu.IB_Alu = alu.EnableAlu ? res_q : {WIDTH{1'bz}};

endmodule
